shift_datapath: RTL and testbench

8-bit load/shift datapath. A constant-select mux feeds a feedback mux, which feeds a 4-function combinational shifter, which feeds a loadable register. The register output is fed back so the block can walk or rotate a bit pattern one position per clock. It is used as a small pattern-generator / shift-register stage in the lab datapath; the submodules are `mux`, `shifter` and `register`.

---
 rtl/shift_datapath.sv | 105 ++++++++++
 tb/tb_shift_datapath.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_datapath.sv
// +----------------------------------------------------------------------+
// | shift_datapath: seed mux -> feedback mux -> shifter -> load register |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mux #(
  parameter int WIDTH = 8
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] out
);
  always_comb begin
    out = in0;
    if (sel == 1'b1) out = in1;
  end
endmodule

module shifter #(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       func,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  always_comb begin
    dout = din;
    case (func)
      2'b00: dout = din;
      2'b01: dout = {din[WIDTH-2:0], 1'b0};
      2'b10: dout = {1'b0, din[WIDTH-1:1]};
      2'b11: dout = {din[WIDTH-2:0], din[WIDTH-1]};
      default: dout = din;
    endcase
  end
endmodule

module register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end
endmodule

module shift_datapath #(
  parameter int               WIDTH  = 8,
  parameter logic [WIDTH-1:0] CONST0 = {1'b1, {WIDTH-1{1'b0}}},
  parameter logic [WIDTH-1:0] CONST1 = {{WIDTH-1{1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             load,
  input  logic             sel_const,
  input  logic             sel_fb,
  input  logic [1:0]       func,
  output logic [WIDTH-1:0] shift_out,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] src;

  mux #(.WIDTH(WIDTH)) u_seed_mux (
    .sel (sel_const),
    .in0 (CONST0),
    .in1 (CONST1),
    .out (seed)
  );

  // The register breaks the feedback path, so q -> src is not a comb loop.
  mux #(.WIDTH(WIDTH)) u_fb_mux (
    .sel (sel_fb),
    .in0 (seed),
    .in1 (q),
    .out (src)
  );

  shifter #(.WIDTH(WIDTH)) u_shifter (
    .func (func),
    .din  (src),
    .dout (shift_out)
  );

  register #(.WIDTH(WIDTH)) u_register (
    .clk     (clk),
    .clear_n (clear_n),
    .load    (load),
    .d       (shift_out),
    .q       (q)
  );
endmodule

`default_nettype wire

// File: tb/tb_shift_datapath.sv
// Self-checking bench for shift_datapath: directed vector table, corner
// sequences, and randomized run against an arithmetic reference model.
`default_nettype none

module tb_shift_datapath;
  logic       clk;
  logic       clear_n;
  logic       load;
  logic       sel_const;
  logic       sel_fb;
  logic [1:0] func;
  logic [7:0] shift_out;
  logic [7:0] q;
  logic [7:0] shift_out2;
  logic [7:0] q2;

  int checks = 0;
  int failures = 0;

  shift_datapath dut (
    .clk       (clk),
    .clear_n   (clear_n),
    .load      (load),
    .sel_const (sel_const),
    .sel_fb    (sel_fb),
    .func      (func),
    .shift_out (shift_out),
    .q         (q)
  );

  shift_datapath #(.WIDTH(8), .CONST0(8'hA5), .CONST1(8'h3C)) dut2 (
    .clk       (clk),
    .clear_n   (clear_n),
    .load      (load),
    .sel_const (sel_const),
    .sel_fb    (sel_fb),
    .func      (func),
    .shift_out (shift_out2),
    .q         (q2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       ld;
    logic       sc;
    logic       fb;
    logic [1:0] fn;
    logic [7:0] so;
    logic [7:0] qx;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Reference shifter from plain arithmetic on the integer value.
  function automatic logic [7:0] ref_shift(input logic [7:0] src, input logic [1:0] f);
    int v;
    int r;
    v = int'(src);
    case (f)
      2'd0:    r = v;
      2'd1:    r = (v * 2) % 256;
      2'd2:    r = v / 2;
      default: r = (v * 2) % 256 + v / 128;
    endcase
    return r[7:0];
  endfunction

  function automatic logic [7:0] ref_out(input logic [7:0] c0, input logic [7:0] c1,
                                         input logic [7:0] qm, input logic sc,
                                         input logic fb, input logic [1:0] f);
    logic [7:0] s;
    s = fb ? qm : (sc ? c1 : c0);
    return ref_shift(s, f);
  endfunction

  task automatic step(input logic ld, input logic sc, input logic fb, input logic [1:0] fn,
                      input logic [7:0] exp_so, input logic [7:0] exp_q, input string name);
    @(negedge clk);
    load = ld; sel_const = sc; sel_fb = fb; func = fn;
    #1 check({name, ".shift_out"}, shift_out, exp_so);
    @(posedge clk);
    #1 check({name, ".q"}, q, exp_q);
  endtask

  initial begin
    logic [7:0] mq1;
    logic [7:0] mq2;
    logic [7:0] e1;
    logic [7:0] e2;

    clear_n = 1'b0; load = 1'b1; sel_const = 1'b0; sel_fb = 1'b1; func = 2'b00;

    // Reset held with load=1 across edges: q stays 0, feedback output is 0.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      func = 2'(i);
      #1 check("reset.shift_out", shift_out, 8'h00);
      @(posedge clk);
      #1 check("reset.q", q, 8'h00);
    end

    // First load on the first edge with clear_n released.
    @(negedge clk);
    clear_n = 1'b1;

    tbl.push_back({1'b1, 1'b1, 1'b0, 2'b00, 8'h01, 8'h01});
    tbl.push_back({1'b1, 1'b0, 1'b0, 2'b00, 8'h80, 8'h80});
    tbl.push_back({1'b1, 1'b1, 1'b0, 2'b01, 8'h02, 8'h02});
    tbl.push_back({1'b1, 1'b0, 1'b1, 2'b01, 8'h04, 8'h04});
    tbl.push_back({1'b1, 1'b0, 1'b1, 2'b01, 8'h08, 8'h08});
    tbl.push_back({1'b1, 1'b0, 1'b1, 2'b01, 8'h10, 8'h10});
    tbl.push_back({1'b1, 1'b0, 1'b1, 2'b01, 8'h20, 8'h20});
    tbl.push_back({1'b1, 1'b0, 1'b1, 2'b01, 8'h40, 8'h40});
    tbl.push_back({1'b1, 1'b0, 1'b1, 2'b01, 8'h80, 8'h80});
    tbl.push_back({1'b1, 1'b0, 1'b1, 2'b01, 8'h00, 8'h00});
    tbl.push_back({1'b1, 1'b0, 1'b1, 2'b11, 8'h00, 8'h00});
    tbl.push_back({1'b1, 1'b0, 1'b1, 2'b10, 8'h00, 8'h00});
    tbl.push_back({1'b1, 1'b0, 1'b0, 2'b00, 8'h80, 8'h80});
    tbl.push_back({1'b1, 1'b0, 1'b1, 2'b11, 8'h01, 8'h01});
    tbl.push_back({1'b1, 1'b0, 1'b1, 2'b11, 8'h02, 8'h02});
    tbl.push_back({1'b1, 1'b0, 1'b0, 2'b10, 8'h40, 8'h40});
    tbl.push_back({1'b0, 1'b0, 1'b1, 2'b00, 8'h40, 8'h40});
    tbl.push_back({1'b0, 1'b0, 1'b1, 2'b01, 8'h80, 8'h40});
    tbl.push_back({1'b0, 1'b0, 1'b1, 2'b11, 8'h80, 8'h40});
    tbl.push_back({1'b0, 1'b1, 1'b0, 2'b10, 8'h00, 8'h40});

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].ld, tbl[i].sc, tbl[i].fb, tbl[i].fn, tbl[i].so, tbl[i].qx,
           $sformatf("vec%0d", i));
    end

    // Rotating 0xA5 (second instance seed) gives 0x4B.
    @(negedge clk);
    sel_fb = 1'b0; sel_const = 1'b0; func = 2'b11;
    #1 check("rot_a5.shift_out", shift_out2, 8'h4B);

    // Mid-run asynchronous clear: reach 0x10 by rotation, then short pulse.
    step(1'b1, 1'b1, 1'b0, 2'b00, 8'h01, 8'h01, "clr_seed");
    step(1'b1, 1'b0, 1'b1, 2'b11, 8'h02, 8'h02, "clr_rot1");
    step(1'b1, 1'b0, 1'b1, 2'b11, 8'h04, 8'h04, "clr_rot2");
    step(1'b1, 1'b0, 1'b1, 2'b11, 8'h08, 8'h08, "clr_rot3");
    step(1'b1, 1'b0, 1'b1, 2'b11, 8'h10, 8'h10, "clr_rot4");
    @(negedge clk);
    #2 clear_n = 1'b0;
    #1 check("clr_pulse.q_low", q, 8'h00);
    clear_n = 1'b1;
    #1 check("clr_pulse.q_after", q, 8'h00);
    check("clr_pulse.shift_out", shift_out, 8'h00);
    step(1'b1, 1'b0, 1'b1, 2'b11, 8'h00, 8'h00, "clr_fb0");
    step(1'b1, 1'b0, 1'b1, 2'b01, 8'h00, 8'h00, "clr_fb1");
    step(1'b1, 1'b1, 1'b0, 2'b00, 8'h01, 8'h01, "clr_reseed");

    // Randomized run on both instances; begins from a clear so models are known.
    @(negedge clk);
    clear_n = 1'b0;
    mq1 = 8'h00;
    mq2 = 8'h00;
    #1 check("rand_start.q", q, 8'h00);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      clear_n   = ($urandom_range(0, 15) != 0);
      load      = ($urandom_range(0, 3) != 0);
      sel_const = 1'($urandom_range(0, 1));
      sel_fb    = ($urandom_range(0, 3) != 0);
      func      = 2'($urandom_range(0, 3));
      if (!clear_n) begin
        mq1 = 8'h00;
        mq2 = 8'h00;
      end
      e1 = ref_out(8'h80, 8'h01, mq1, sel_const, sel_fb, func);
      e2 = ref_out(8'hA5, 8'h3C, mq2, sel_const, sel_fb, func);
      #1;
      check("rand.shift_out", shift_out, e1);
      check("rand.shift_out2", shift_out2, e2);
      @(posedge clk);
      if (clear_n && load) begin
        mq1 = e1;
        mq2 = e2;
      end
      #1;
      check("rand.q", q, mq1);
      check("rand.q2", q2, mq2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
